uart_tx_serializer: RTL and testbench
=====================================

Name: uart_tx_serializer

Overview:
- Downstream consumer of the byte-generator stage (the module that emits ASCII characters on uart_clk).
- Accepts bytes over a valid/ready handshake into a small FIFO.
- Serializes them onto the UART line as 8N1 frames, LSB first.
- Reports line/queue status back upstream so the generator can pace its characters.

Parameters:
- CLKS_PER_BIT, 16: uart_clk cycles per serial bit; legal range ≥ 2.
- FIFO_DEPTH, 4: byte queue entries; must be a power of two, ≥ 2.
- LEVEL_W, 3: width of fifo_level; equals log2(FIFO_DEPTH)+1.

Ports:
- uart_clk, input, 1: sole clock; all logic on its rising edge.
- rst, input, 1: synchronous, active-high reset.
- data_in, input, 8: byte to transmit.
- data_valid, input, 1: upstream presents data_in.
- data_ready, output, 1: block can accept a byte this cycle.
- tx, output, 1: serial line; idle high.
- tx_busy, output, 1: a frame is on the line.
- tx_ready, output, 1: idle and FIFO empty; everything drained.
- fifo_level, output, LEVEL_W: bytes queued, not counting the one in flight.

Behaviour:
- Reset: takes effect on the first rising edge with rst=1, including mid-frame.
  - tx=1, tx_busy=0, tx_ready=1, fifo_level=0.
  - FIFO emptied; state=IDLE; bit and baud counters=0.
  - data_ready=0 while rst=1.
  - A partially sent frame is abandoned; tx returns high on the next edge.
- Handshake:
  - data_ready = !full && !rst (combinational).
  - Push occurs on an edge where data_valid && data_ready.
  - data_in is captured on that edge; upstream may change it afterwards.
  - data_valid while full is ignored, with no loss of queued data; upstream must hold the byte.
- FIFO:
  - Circular buffer; read/write pointers wrap modulo FIFO_DEPTH.
  - full when fifo_level==FIFO_DEPTH; empty when fifo_level==0.
  - Push and pop on the same edge leaves fifo_level unchanged.
  - A push on the same edge as a pop from a full FIFO is not possible (data_ready=0).
  - A push into an empty FIFO is not visible to the pop logic until the next cycle.
- State machine (registered tx):
  - IDLE: tx=1. If FIFO non-empty: pop the head into the shift register, clear baud_cnt, go to START.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit_idx=0.
  - DATA: tx=shift[0] for CLKS_PER_BIT cycles, then shift right and increment bit_idx. After bit_idx 7, go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. At the end, if FIFO non-empty, pop and go straight to START (back-to-back frames, no idle gap); else go to IDLE.
- baud_cnt counts 0..CLKS_PER_BIT-1; the bit boundary is at baud_cnt==CLKS_PER_BIT-1.
- Latency:
  - Push at edge t into an empty, idle block: pop at edge t+1; tx falls at edge t+2.
  - Frame length is exactly 10*CLKS_PER_BIT cycles.
  - Back-to-back frames have period 10*CLKS_PER_BIT.
- Status flags:
  - tx_busy=1 in START, DATA and STOP.
  - tx_ready = (state==IDLE) && empty. It goes high on the edge the last stop bit completes with an empty FIFO.

Test Plan:
- CLKS_PER_BIT=4, single push 8'h4D ('M') into idle block → tx low from t+2 for 4 cycles. Then bits 1,0,1,1,0,0,1,0 at 4 cycles each, stop high 4 cycles. tx_ready returns 1 at t+42.
- Push 'M','a','t','r' on consecutive cycles → data_ready stays 1. Frames are contiguous with no idle between stop and next start. Decoded sequence is 4D,61,74,72.
- Burst of 6 bytes with FIFO_DEPTH=4 → data_ready drops to 0 after 5 accepted (4 queued + 1 in flight). fifo_level peaks at 4. The 6th byte is accepted once the first pop frees a slot; no byte is lost or duplicated.
- rst asserted during DATA bit 3 of 8'hA5, with 2 bytes queued → next edge gives tx=1, fifo_level=0, tx_busy=0. After release no residual frame is sent.
- Push on the exact STOP-end cycle while FIFO empty → state goes to IDLE. The pop occurs one cycle later, so the next start bit begins 1 cycle after the stop bit ends.
- data_valid held high while full with data_in changing → only the value present on the accepting edge is transmitted.

Source files
------------

// File: rtl/uart_tx_serializer.sv
// Byte-queue fed 8N1 UART transmitter: a small circular FIFO in front of a
// start/data/stop serializer, with line and queue status for the upstream producer.
module uart_tx_serializer #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4,
    parameter int LEVEL_W      = 3
) (
    input  logic               uart_clk,
    input  logic               rst,
    input  logic [7:0]         data_in,
    input  logic               data_valid,
    output logic               data_ready,
    output logic               tx,
    output logic               tx_busy,
    output logic               tx_ready,
    output logic [LEVEL_W-1:0] fifo_level
);

    localparam int PTR_W = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0]   BAUD_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [LEVEL_W-1:0] LEVEL_FULL = LEVEL_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    logic [7:0]         mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [LEVEL_W-1:0] level_q;
    logic [LEVEL_W-1:0] level_d;
    state_t             state_q;
    logic [CNT_W-1:0]   baud_q;
    logic [2:0]         bit_q;
    logic [7:0]         shift_q;
    logic               tx_q;
    logic               busy_q;
    logic               ready_q;

    logic full_s;
    logic empty_s;
    logic push_s;
    logic pop_s;
    logic bit_end_s;

    assign full_s     = (level_q == LEVEL_FULL);
    assign empty_s    = (level_q == {LEVEL_W{1'b0}});
    assign data_ready = !full_s && !rst;
    assign push_s     = data_valid && data_ready;
    assign bit_end_s  = (baud_q == BAUD_LAST);

    assign tx         = tx_q;
    assign tx_busy    = busy_q;
    assign tx_ready   = ready_q;
    assign fifo_level = level_q;

    // Pop decision uses the registered level, so a fresh push is seen one cycle later.
    always_comb begin
        pop_s   = 1'b0;
        level_d = level_q;
        if (empty_s) begin
            pop_s = 1'b0;
        end else if (state_q == IDLE) begin
            pop_s = 1'b1;
        end else if ((state_q == STOP) && bit_end_s) begin
            pop_s = 1'b1;
        end else begin
            pop_s = 1'b0;
        end
        case ({push_s, pop_s})
            2'b10:   level_d = level_q + LEVEL_W'(1);
            2'b01:   level_d = level_q - LEVEL_W'(1);
            default: level_d = level_q;
        endcase
    end

    // Byte storage; push_s is already blocked while rst is high.
    always_ff @(posedge uart_clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= data_in;
        end
    end

    // Queue pointers and occupancy; pointers wrap naturally at a power-of-two depth.
    always_ff @(posedge uart_clk) begin
        if (rst) begin
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            level_q  <= {LEVEL_W{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            level_q <= level_d;
        end
    end

    // Frame sequencer; outputs are registered from the current state, one cycle behind it.
    always_ff @(posedge uart_clk) begin
        if (rst) begin
            state_q <= IDLE;
            baud_q  <= {CNT_W{1'b0}};
            bit_q   <= 3'd0;
            shift_q <= 8'h00;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pop_s) begin
                        shift_q <= mem_q[rd_ptr_q];
                        baud_q  <= {CNT_W{1'b0}};
                        state_q <= START;
                    end
                end
                START: begin
                    if (bit_end_s) begin
                        baud_q  <= {CNT_W{1'b0}};
                        bit_q   <= 3'd0;
                        state_q <= DATA;
                    end else begin
                        baud_q <= baud_q + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (bit_end_s) begin
                        baud_q  <= {CNT_W{1'b0}};
                        shift_q <= {1'b0, shift_q[7:1]};
                        if (bit_q == 3'd7) begin
                            state_q <= STOP;
                        end else begin
                            bit_q <= bit_q + 3'd1;
                        end
                    end else begin
                        baud_q <= baud_q + CNT_W'(1);
                    end
                end
                STOP: begin
                    if (bit_end_s) begin
                        baud_q <= {CNT_W{1'b0}};
                        if (pop_s) begin
                            shift_q <= mem_q[rd_ptr_q];
                            state_q <= START;
                        end else begin
                            state_q <= IDLE;
                        end
                    end else begin
                        baud_q <= baud_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase

            case (state_q)
                START:   tx_q <= 1'b0;
                DATA:    tx_q <= shift_q[0];
                default: tx_q <= 1'b1;
            endcase
            busy_q  <= (state_q != IDLE);
            ready_q <= (state_q == IDLE) && empty_s;
        end
    end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Randomized bench: every accepted byte is scheduled as a 10-bit frame on a
// timeline model; line, status flags and queue level are compared every cycle.
module tb_uart_tx_serializer;

    localparam int C  = 4;
    localparam int D  = 4;
    localparam int LW = 3;

    logic          uart_clk = 1'b0;
    logic          rst = 1'b1;
    logic [7:0]    data_in = 8'h00;
    logic          data_valid = 1'b0;
    logic          data_ready;
    logic          tx;
    logic          tx_busy;
    logic          tx_ready;
    logic [LW-1:0] fifo_level;

    uart_tx_serializer #(.CLKS_PER_BIT(C), .FIFO_DEPTH(D), .LEVEL_W(LW)) dut (
        .uart_clk   (uart_clk),
        .rst        (rst),
        .data_in    (data_in),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .tx         (tx),
        .tx_busy    (tx_busy),
        .tx_ready   (tx_ready),
        .fifo_level (fifo_level)
    );

    always #5 uart_clk = ~uart_clk;

    typedef struct {int st; logic [7:0] b;} frame_t;

    frame_t fq[$];
    int     prev_end = 0;
    int     n_cmp = 0;
    int     n_bad = 0;
    int     cyc_n = 0;
    int     peak = 0;

    // A byte is still queued while its pop edge (one before its start bit) lies ahead.
    function automatic int level_at(input int m);
        int c;
        c = 0;
        foreach (fq[i]) if (fq[i].st - 1 > m) c++;
        return c;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0h expected %0h at cycle %0d", tag, obs, exp, cyc_n);
        end
    endtask

    task automatic cyc(input logic v, input logic [7:0] d, input logic r, output logic acc);
        logic exp_rdy;
        logic exp_tx;
        logic exp_busy;
        logic exp_ready;
        int   old_lvl;
        int   off;
        int   st;
        data_valid = v;
        data_in    = d;
        rst        = r;
        #1;
        exp_rdy = !r && (level_at(cyc_n) < D);
        check_eq("data_ready", data_ready, exp_rdy);
        acc = v && exp_rdy;
        @(posedge uart_clk);
        cyc_n++;
        old_lvl = level_at(cyc_n - 1);
        if (r) begin
            fq.delete();
            prev_end = 0;
            old_lvl  = 0;
        end else if (acc) begin
            st = (cyc_n + 2 > prev_end) ? cyc_n + 2 : prev_end;
            fq.push_back('{st, d});
            prev_end = st + 10 * C;
        end
        while (fq.size() > 0 && fq[0].st + 10 * C <= cyc_n) void'(fq.pop_front());
        exp_tx   = 1'b1;
        exp_busy = 1'b0;
        foreach (fq[i]) begin
            if (fq[i].st <= cyc_n && cyc_n < fq[i].st + 10 * C) begin
                exp_busy = 1'b1;
                off = (cyc_n - fq[i].st) / C;
                if (off == 0) exp_tx = 1'b0;
                else if (off <= 8) exp_tx = fq[i].b[off - 1];
                else exp_tx = 1'b1;
            end
        end
        exp_ready = !exp_busy && (old_lvl == 0);
        @(negedge uart_clk);
        check_eq("tx", tx, exp_tx);
        check_eq("tx_busy", tx_busy, exp_busy);
        check_eq("tx_ready", tx_ready, exp_ready);
        check_eq("fifo_level", fifo_level, level_at(cyc_n));
        if (int'(fifo_level) > peak) peak = int'(fifo_level);
    endtask

    task automatic idle(input int k);
        logic a;
        repeat (k) cyc(1'b0, 8'h00, 1'b0, a);
    endtask

    // Present one byte and hold it until it is taken, changing nothing else.
    task automatic push_hold(input logic [7:0] b);
        logic a;
        int   g;
        g = 0;
        do begin
            cyc(1'b1, b, 1'b0, a);
            g++;
        end while (!a && g < 200);
    endtask

    initial begin
        logic       a;
        int         t;
        int         g;
        logic [7:0] msg [4];
        msg[0] = 8'h4D; msg[1] = 8'h61; msg[2] = 8'h74; msg[3] = 8'h72;

        @(negedge uart_clk);
        repeat (3) cyc(1'b0, 8'h00, 1'b1, a);
        idle(2);

        // Single 'M' into an idle block, drained fully.
        cyc(1'b1, 8'h4D, 1'b0, a);
        idle(50);

        // Four consecutive pushes: contiguous frames.
        for (int k = 0; k < 4; k++) cyc(1'b1, msg[k], 1'b0, a);
        idle(170);

        // Six-byte burst against a four-entry queue.
        peak = 0;
        for (int k = 0; k < 6; k++) push_hold(8'($urandom));
        check_eq("peak_level", peak, 4);
        idle(260);

        // Reset during data bit 3 of 8'hA5 with two bytes queued.
        cyc(1'b1, 8'hA5, 1'b0, a);
        t = cyc_n;
        cyc(1'b1, 8'($urandom), 1'b0, a);
        cyc(1'b1, 8'($urandom), 1'b0, a);
        while (cyc_n < t + 2 + 4 * C + 1) idle(1);
        cyc(1'b0, 8'h00, 1'b1, a);
        idle(60);

        // Push landing exactly on the stop-end edge of a lone frame.
        cyc(1'b1, 8'($urandom), 1'b0, a);
        t = cyc_n;
        while (cyc_n < t + 10 * C) idle(1);
        cyc(1'b1, 8'($urandom), 1'b0, a);
        idle(50);

        // Fill the queue, then hold valid with data changing every cycle.
        for (int k = 0; k < 5; k++) cyc(1'b1, 8'($urandom), 1'b0, a);
        g = 0;
        do begin
            cyc(1'b1, 8'($urandom), 1'b0, a);
            g++;
        end while (!a && g < 200);
        idle(260);

        // Free-running random traffic with occasional resets.
        for (int k = 0; k < 2000; k++) begin
            cyc(($urandom_range(0, 2) != 0), 8'($urandom), ($urandom_range(0, 299) == 0), a);
        end
        idle(300);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
